// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared opcodes, header size and parser state encoding for the
//            ALU packet front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [7:0]  C_OPC_ECHO  = 8'hEC;
    localparam logic [7:0]  C_OPC_ADD   = 8'hA0;
    localparam logic [7:0]  C_OPC_MUL   = 8'hA1;
    localparam logic [7:0]  C_OPC_DIV   = 8'hA2;

    localparam logic [15:0] C_HDR_BYTES = 16'd4;

    typedef enum logic [2:0] {
        ST_OPCODE  = 3'd0,
        ST_RSVD    = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_LEN_HI  = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_EMIT    = 3'd5,
        ST_DRAIN   = 3'd6
    } state_t;

    function automatic logic opcode_known(input logic [7:0] opc);
        return (opc == C_OPC_ECHO) || (opc == C_OPC_ADD) ||
               (opc == C_OPC_MUL)  || (opc == C_OPC_DIV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_packet_parser.sv
// ============================================================================
// Module   : alu_packet_parser
// Purpose  : Turns a UART byte stream of headed packets into little-endian
//            32-bit operands for the ALU datapath, flagging malformed packets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_packet_parser
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH_P    = 8,
    parameter int OPERAND_WIDTH_P = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH_P-1:0]    rx_data_i,
    input  logic                       rx_valid_i,
    output logic                       rx_ready_o,
    output logic                       op_valid_o,
    input  logic                       op_ready_i,
    output logic [OPERAND_WIDTH_P-1:0] op_data_o,
    output logic [7:0]                 opcode_o,
    output logic                       op_first_o,
    output logic                       op_last_o,
    output logic                       err_o
);

    state_t                       state_q,     state_d;
    logic [15:0]                  remaining_q, remaining_d;
    logic [7:0]                   len_lo_q,    len_lo_d;
    logic [7:0]                   opcode_q,    opcode_d;
    logic [OPERAND_WIDTH_P-1:0]   op_data_q,   op_data_d;
    logic [1:0]                   lane_q,      lane_d;
    logic                         first_pend_q, first_pend_d;
    logic                         op_valid_q,  op_valid_d;
    logic                         op_first_q,  op_first_d;
    logic                         op_last_q,   op_last_d;
    logic                         err_q,       err_d;
    logic                         rx_ready_q,  rx_ready_d;

    logic                         accept;
    logic [15:0]                  hdr_len;
    logic [15:0]                  payload_len;

    assign accept      = rx_valid_i & rx_ready_q;
    assign hdr_len     = {rx_data_i[7:0], len_lo_q};
    assign payload_len = hdr_len - C_HDR_BYTES;

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        len_lo_d     = len_lo_q;
        opcode_d     = opcode_q;
        op_data_d    = op_data_q;
        lane_d       = lane_q;
        first_pend_d = first_pend_q;
        op_valid_d   = op_valid_q;
        op_first_d   = op_first_q;
        op_last_d    = op_last_q;
        err_d        = 1'b0;

        case (state_q)
            ST_OPCODE: if (accept) begin
                opcode_d = rx_data_i[7:0];
                state_d  = ST_RSVD;
            end
            ST_RSVD: if (accept) begin
                state_d = ST_LEN_LO;
            end
            ST_LEN_LO: if (accept) begin
                len_lo_d = rx_data_i[7:0];
                state_d  = ST_LEN_HI;
            end
            ST_LEN_HI: if (accept) begin
                if (hdr_len < C_HDR_BYTES) begin
                    err_d   = 1'b1;
                    state_d = ST_OPCODE;
                end else if (!opcode_known(opcode_q) || (payload_len == 16'd0) ||
                             (payload_len[1:0] != 2'd0)) begin
                    // Malformed but length is trustworthy: swallow the body.
                    err_d       = 1'b1;
                    remaining_d = payload_len;
                    state_d     = (payload_len == 16'd0) ? ST_OPCODE : ST_DRAIN;
                end else begin
                    remaining_d  = payload_len;
                    lane_d       = 2'd0;
                    first_pend_d = 1'b1;
                    state_d      = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: if (accept) begin
                op_data_d[lane_q*DATA_WIDTH_P +: DATA_WIDTH_P] = rx_data_i;
                remaining_d = remaining_q - 16'd1;
                lane_d      = lane_q + 2'd1;
                if (lane_q == 2'd3) begin
                    op_valid_d   = 1'b1;
                    op_first_d   = first_pend_q;
                    op_last_d    = (remaining_q == 16'd1);
                    first_pend_d = 1'b0;
                    state_d      = ST_EMIT;
                end
            end
            ST_EMIT: if (op_ready_i) begin
                op_valid_d = 1'b0;
                op_first_d = 1'b0;
                op_last_d  = 1'b0;
                state_d    = (remaining_q == 16'd0) ? ST_OPCODE : ST_PAYLOAD;
            end
            ST_DRAIN: if (accept) begin
                remaining_d = remaining_q - 16'd1;
                if (remaining_q == 16'd1) begin
                    state_d = ST_OPCODE;
                end
            end
            default: state_d = ST_OPCODE;
        endcase

        // Registered ready tracks the next state so EMIT backpressures with no bubble.
        rx_ready_d = (state_d != ST_EMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_OPCODE;
            remaining_q  <= '0;
            len_lo_q     <= '0;
            opcode_q     <= '0;
            op_data_q    <= '0;
            lane_q       <= '0;
            first_pend_q <= 1'b0;
            op_valid_q   <= 1'b0;
            op_first_q   <= 1'b0;
            op_last_q    <= 1'b0;
            err_q        <= 1'b0;
            rx_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            len_lo_q     <= len_lo_d;
            opcode_q     <= opcode_d;
            op_data_q    <= op_data_d;
            lane_q       <= lane_d;
            first_pend_q <= first_pend_d;
            op_valid_q   <= op_valid_d;
            op_first_q   <= op_first_d;
            op_last_q    <= op_last_d;
            err_q        <= err_d;
            rx_ready_q   <= rx_ready_d;
        end
    end

    assign rx_ready_o = rx_ready_q;
    assign op_valid_o = op_valid_q;
    assign op_data_o  = op_data_q;
    assign opcode_o   = opcode_q;
    assign op_first_o = op_first_q;
    assign op_last_o  = op_last_q;
    assign err_o      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_packet_parser.sv
// ============================================================================
// Module   : tb_alu_packet_parser
// Purpose  : Self-checking bench: directed packet table, backpressure and
//            reset sequences, and a random stream against a packet-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_packet_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic        op_valid_o;
    logic        op_ready_i;
    logic [31:0] op_data_o;
    logic [7:0]  opcode_o;
    logic        op_first_o;
    logic        op_last_o;
    logic        err_o;

    always #5 clk = ~clk;

    alu_packet_parser #(
        .DATA_WIDTH_P    (8),
        .OPERAND_WIDTH_P (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .op_valid_o (op_valid_o),
        .op_ready_i (op_ready_i),
        .op_data_o  (op_data_o),
        .opcode_o   (opcode_o),
        .op_first_o (op_first_o),
        .op_last_o  (op_last_o),
        .err_o      (err_o)
    );

    typedef struct {
        logic [7:0]  opcode;
        logic [31:0] data;
        logic        is_first;
        logic        is_last;
    } op_t;

    typedef struct {
        int           n;
        logic [127:0] bytes;
        int           exp_ops;
        int           exp_errs;
        logic [7:0]   exp_opc;
        logic [31:0]  exp_first;
        logic [31:0]  exp_last;
    } vec_t;

    op_t        got_q[$];
    op_t        exp_q[$];
    logic [7:0] stream[$];
    int         err_seen;
    int         exp_err;
    int         n_checks = 0;
    int         n_errors = 0;
    bit         rand_ready = 1'b0;
    vec_t       vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Called at a falling edge once the inputs for the coming rising edge are set.
    task automatic observe();
        if (op_valid_o && op_ready_i)
            got_q.push_back('{opcode: opcode_o, data: op_data_o,
                              is_first: op_first_o, is_last: op_last_o});
        if (err_o) err_seen++;
    endtask

    task automatic tick();
        if (rand_ready) op_ready_i = ($urandom_range(0, 3) != 0);
        observe();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_valid_i = 1'b0;
        repeat (n) tick();
    endtask

    task automatic flush();
        rand_ready = 1'b0;
        op_ready_i = 1'b1;
        idle(12);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done       = 1'b0;
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        for (int t = 0; t < 200 && !done; t++) begin
            done = rx_ready_o;
            tick();
        end
        rx_valid_i = 1'b0;
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_byte: byte 0x%0h not accepted within 200 cycles", b);
        end
    endtask

    task automatic send_stream(input logic [7:0] s[$], input bit gaps);
        foreach (s[i]) begin
            if (gaps) idle($urandom_range(0, 2));
            send_byte(s[i]);
        end
    endtask

    // Packet-level reference: walks a whole byte stream header by header.
    function automatic void model(input logic [7:0] s[$]);
        int         i;
        int         len;
        int         nops;
        logic [7:0] opc;
        bit         known;
        exp_q.delete();
        exp_err = 0;
        i = 0;
        while (i + 4 <= s.size()) begin
            opc   = s[i];
            len   = int'(s[i+2]) + 256 * int'(s[i+3]);
            i    += 4;
            known = (opc == 8'hEC) || (opc == 8'hA0) || (opc == 8'hA1) || (opc == 8'hA2);
            if (len < 4) begin
                exp_err++;
            end else if (!known || len == 4 || ((len - 4) % 4) != 0) begin
                exp_err++;
                i += len - 4;
            end else begin
                nops = (len - 4) / 4;
                for (int k = 0; k < nops; k++) begin
                    exp_q.push_back('{opcode: opc,
                                      data: {s[i+3], s[i+2], s[i+1], s[i]},
                                      is_first: (k == 0), is_last: (k == nops - 1)});
                    i += 4;
                end
            end
        end
    endfunction

    task automatic compare_model(input string tag);
        int n;
        check({tag, " op count"}, got_q.size(), exp_q.size());
        check({tag, " err pulses"}, err_seen, exp_err);
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s op%0d data", tag, i), got_q[i].data, exp_q[i].data);
            check($sformatf("%s op%0d opcode", tag, i), got_q[i].opcode, exp_q[i].opcode);
            check($sformatf("%s op%0d first/last", tag, i),
                  {got_q[i].is_first, got_q[i].is_last}, {exp_q[i].is_first, exp_q[i].is_last});
        end
    endtask

    function automatic void push_rand_packet();
        int         kind;
        int         k;
        int         len;
        logic [7:0] opc;
        logic [7:0] valid_opc[4];
        valid_opc = '{8'hEC, 8'hA0, 8'hA1, 8'hA2};
        kind = $urandom_range(0, 6);
        k    = $urandom_range(1, 3);
        opc  = valid_opc[$urandom_range(0, 3)];
        len  = 4 + 4 * k;
        case (kind)
            3: begin
                do opc = 8'($urandom_range(0, 255));
                while (opc == 8'hEC || opc == 8'hA0 || opc == 8'hA1 || opc == 8'hA2);
            end
            4: len = 4 + 4 * k + $urandom_range(1, 3);
            5: len = $urandom_range(0, 3);
            6: len = 4;
            default: ;
        endcase
        stream.push_back(opc);
        stream.push_back(8'($urandom_range(0, 255)));
        stream.push_back(8'(len));
        stream.push_back(8'(len >> 8));
        if (len > 4)
            for (int b = 0; b < len - 4; b++) stream.push_back(8'($urandom_range(0, 255)));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{12, 128'hA0000C00_01000000_02000000_00000000, 2, 0, 8'hA0, 32'h00000001, 32'h00000002};
        vecs[1] = '{16, 128'h55000800_11223344_EC000800_78563412, 1, 1, 8'hEC, 32'h12345678, 32'h12345678};
        vecs[2] = '{15, 128'hA1000700_AABBCCEC_00080001_02030400, 1, 1, 8'hEC, 32'h04030201, 32'h04030201};
        vecs[3] = '{12, 128'hA0000200_EC000800_05060708_00000000, 1, 1, 8'hEC, 32'h08070605, 32'h08070605};
        vecs[4] = '{12, 128'hA2000400_EC000800_0A0B0C0D_00000000, 1, 1, 8'hEC, 32'h0D0C0B0A, 32'h0D0C0B0A};
        vecs[5] = '{16, 128'hA1001000_01020304_05060708_090A0B0C, 3, 0, 8'hA1, 32'h04030201, 32'h0C0B0A09};

        rst        = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        op_ready_i = 1'b1;
        err_seen   = 0;

        #1;
        check("reset rx_ready", rx_ready_o, 0);
        check("reset op_valid", op_valid_o, 0);
        check("reset op_data", op_data_o, 0);
        check("reset opcode", opcode_o, 0);
        check("reset first/last/err", {op_first_o, op_last_o, err_o}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rx_ready before first edge", rx_ready_o, 0);
        @(negedge clk);
        check("rx_ready after first edge", rx_ready_o, 1);

        foreach (vecs[v]) begin
            got_q.delete();
            err_seen = 0;
            for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].bytes[127 - 8*i -: 8]);
            flush();
            check($sformatf("vec%0d op count", v), got_q.size(), vecs[v].exp_ops);
            check($sformatf("vec%0d err pulses", v), err_seen, vecs[v].exp_errs);
            if (got_q.size() == vecs[v].exp_ops && vecs[v].exp_ops > 0) begin
                check($sformatf("vec%0d first data", v), got_q[0].data, vecs[v].exp_first);
                check($sformatf("vec%0d opcode", v), got_q[0].opcode, vecs[v].exp_opc);
                check($sformatf("vec%0d first flag", v), got_q[0].is_first, 1);
                check($sformatf("vec%0d last data", v), got_q[$].data, vecs[v].exp_last);
                check($sformatf("vec%0d last flag", v), got_q[$].is_last, 1);
                if (vecs[v].exp_ops > 1)
                    check($sformatf("vec%0d op0 not last", v), got_q[0].is_last, 0);
            end
        end

        // Backpressure: hold the first operand for 10 cycles with a byte waiting.
        begin
            logic [7:0] hdr[8];
            bit bp_ready_seen, bp_data_moved, bp_valid_dropped;
            hdr = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
            got_q.delete();
            err_seen         = 0;
            bp_ready_seen    = 1'b0;
            bp_data_moved    = 1'b0;
            bp_valid_dropped = 1'b0;
            op_ready_i       = 1'b0;
            foreach (hdr[i]) send_byte(hdr[i]);
            for (int c = 0; c < 10; c++) begin
                rx_valid_i = 1'b1;
                rx_data_i  = 8'h02;
                if (rx_ready_o) bp_ready_seen = 1'b1;
                if (op_data_o !== 32'h00000001) bp_data_moved = 1'b1;
                if (!op_valid_o || !op_first_o) bp_valid_dropped = 1'b1;
                tick();
            end
            check("bp rx_ready held low", bp_ready_seen, 0);
            check("bp op_data stable", bp_data_moved, 0);
            check("bp op_valid/first held", bp_valid_dropped, 0);
            op_ready_i = 1'b1;
            send_byte(8'h02);
            send_byte(8'h00);
            send_byte(8'h00);
            send_byte(8'h00);
            flush();
            stream.delete();
            foreach (hdr[i]) stream.push_back(hdr[i]);
            stream.push_back(8'h02); stream.push_back(8'h00);
            stream.push_back(8'h00); stream.push_back(8'h00);
            model(stream);
            compare_model("bp");
        end

        // Reset mid-packet clears outputs asynchronously and discards the fragment.
        begin
            logic [7:0] frag[6];
            frag = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00};
            foreach (frag[i]) send_byte(frag[i]);
            #2 rst = 1'b1;
            #1;
            check("async rst opcode", opcode_o, 0);
            check("async rst op_data", op_data_o, 0);
            check("async rst rx_ready/op_valid", {rx_ready_o, op_valid_o}, 0);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            got_q.delete();
            err_seen = 0;
            stream.delete();
            stream = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00,
                       8'h30, 8'h00, 8'h00, 8'h00};
            model(stream);
            send_stream(stream, 1'b0);
            flush();
            compare_model("post-reset");
        end

        // Random stream, led by a 16-bit length drain (0x0105) and random op_ready.
        begin
            got_q.delete();
            err_seen = 0;
            stream.delete();
            stream.push_back(8'hA1); stream.push_back(8'h00);
            stream.push_back(8'h05); stream.push_back(8'h01);
            for (int b = 0; b < 257; b++) stream.push_back(8'($urandom_range(0, 255)));
            for (int p = 0; p < 30; p++) push_rand_packet();
            model(stream);
            rand_ready = 1'b1;
            send_stream(stream, 1'b1);
            flush();
            compare_model("random");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_packet_parser.md
ALU_PACKET_PARSER -- requirements
Module: alu_packet_parser

Interface
REQ-001 SHALL have parameter DATA_WIDTH_P, default 8, meaning the width of the UART byte stream.
REQ-002 SHALL have parameter OPERAND_WIDTH_P, default 32, meaning the width of an assembled operand (4 bytes).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port rx_data_i  input  DATA_WIDTH_P  byte from the UART receiver (m_axis_tdata).
REQ-006 SHALL have port rx_valid_i  input  1  byte valid (m_axis_tvalid).
REQ-007 SHALL have port rx_ready_o  output  1  byte accepted when rx_valid_i & rx_ready_o (m_axis_tready).
REQ-008 SHALL have port op_valid_o  output  1  operand valid toward the ALU datapath.
REQ-009 SHALL have port op_ready_i  input  1  ALU datapath accepts the operand.
REQ-010 SHALL have port op_data_o  output  OPERAND_WIDTH_P  assembled operand, little-endian.
REQ-011 SHALL have port opcode_o  output  8  opcode of the current packet, stable while op_valid_o.
REQ-012 SHALL have port op_first_o / op_last_o  output  1 each  first/last operand of the packet.
REQ-013 SHALL have port err_o  output  1  one-cycle pulse on a malformed packet.

Function
REQ-014 Packet format SHALL be: byte0 opcode, byte1 reserved (ignored), byte2 length LSB, byte3 length MSB; length = total bytes including the 4-byte header.
REQ-015 Valid opcodes SHALL be 0xEC echo, 0xA0 add, 0xA1 mul, 0xA2 div.
REQ-016 FSM states SHALL be OPCODE, RSVD, LEN_LO, LEN_HI, PAYLOAD, EMIT, DRAIN; each header state advances on one accepted byte.
REQ-017 At LEN_HI acceptance, len<4 SHALL pulse err_o and go to OPCODE.
REQ-018 At LEN_HI acceptance, an unknown opcode, len==4, or (len-4) not a multiple of 4 SHALL pulse err_o and go to DRAIN with remaining=len-4 (len==4 returns directly to OPCODE).
REQ-019 Otherwise it SHALL load a 16-bit remaining counter with len-4 and enter PAYLOAD.
REQ-020 PAYLOAD SHALL shift each accepted byte into op_data_o at byte lane (byte index mod 4), decrementing remaining; the 4th byte SHALL move to EMIT.
REQ-021 op_valid_o SHALL assert the cycle after the 4th byte is accepted; latency 1 cycle.
REQ-022 rx_ready_o SHALL be 1 in every state except EMIT and reset; 0 in EMIT (backpressure).
REQ-023 In EMIT, op_valid_o and op_data_o/opcode_o/op_first_o/op_last_o SHALL be held until op_ready_i; on handshake go to OPCODE if remaining==0, else PAYLOAD.
REQ-024 op_first_o SHALL be 1 only for the first operand of a packet; op_last_o SHALL be 1 iff remaining==0.
REQ-025 DRAIN SHALL accept and discard bytes until remaining==0, then go to OPCODE; no op_valid_o.
REQ-026 Length arithmetic SHALL be 16-bit unsigned; len=0xFFFF with a bad multiple SHALL drain 65531 bytes without wrap.

Reset
REQ-027 Assertion of rst SHALL immediately force state OPCODE, remaining=0, op_valid_o=0, rx_ready_o=0, err_o=0, op_data_o=0, opcode_o=0, op_first_o=0, op_last_o=0.
REQ-028 rx_ready_o SHALL be 1 from the first clock edge after rst deasserts; reset mid-packet SHALL discard the partial packet.

Structure
REQ-029 Opcode constants, header byte count (4), and the state enum SHALL live in a shared package alu_pkg.
REQ-030 Design SHALL be a single module with no sub-modules; the byte-to-word shift register SHALL be inline.

Verification
REQ-031 Add: bytes A0 00 0C 00, 01 00 00 00, 02 00 00 00 -> two operands 0x00000001 (first) and 0x00000002 (last), opcode 0xA0, no err_o.
REQ-032 Backpressure: same packet with op_ready_i held 0 for 10 cycles -> rx_ready_o=0 and op_data_o stable throughout; no byte lost.
REQ-033 Bad opcode: 55 00 08 00 then 4 bytes, then a valid echo packet -> err_o one pulse, no operand, echo packet parsed correctly.
REQ-034 Bad length: A1 00 07 00 + 3 bytes -> err_o pulse, 3 bytes drained, back to OPCODE.
REQ-035 Short length: A0 00 02 00 -> err_o pulse, next byte treated as opcode.
REQ-036 Reset mid-packet: rst asserted after 6 bytes of an add packet -> all outputs 0 asynchronously; a subsequent full packet parses correctly.
